alu_multiword_sequencer: RTL

Sequences a WIDTH-bit add/sub/logic slice across WORDS operand words, least-significant word first, so the ALU can execute WORDS×WIDTH-bit operations. It chains carry between words, accumulates the zero flag, and derives N/C/V from the final word. Overflow uses the team's add/sub sign rule. It sits between the operand-fetch logic, which streams word pairs, and the flag register consumer.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_word_slice.sv | 34 +++
 rtl/alu_multiword_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the multi-word ALU sequencer: op encodings, FSM states
// and bit positions inside the {N,Z,C,V} flag vector.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_word_slice.sv
// One WIDTH-bit slice of the ALU: add/sub with carry in, AND, OR, and the
// signed-overflow term taken from this word's MSBs.
module alu_word_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] sum;

    // Subtract is a + ~b + cin; the caller seeds cin=1 on the first word.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b ^ {WIDTH{op[0]}}} + {{WIDTH{1'b0}}, cin};
        r    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        if (op == OP_AND) begin
            r    = a & b;
            cout = 1'b0;
        end else if (op == OP_OR) begin
            r    = a | b;
            cout = 1'b0;
        end
        ovf = ~op[1] & (a[WIDTH-1] ^ r[WIDTH-1]) & ~(a[WIDTH-1] ^ b[WIDTH-1] ^ op[0]);
    end

endmodule

// File: rtl/alu_multiword_sequencer.sv
// Streams WORDS operand pairs LSW first through one ALU slice, chaining carry
// and zero between words and registering N/Z/C/V alongside the done pulse.
module alu_multiword_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int                CNT_W = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic             done_q, done_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] slice_r;
    logic             slice_cout;
    logic             slice_ovf;

    alu_word_slice #(.WIDTH(WIDTH)) u_slice (
        .a    (a_word),
        .b    (b_word),
        .op   (op_q),
        .cin  (carry_q),
        .r    (slice_r),
        .cout (slice_cout),
        .ovf  (slice_ovf)
    );

    // Flags are only updated on the last transfer, so they hold between operations.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        out_valid_d = 1'b0;
        out_word_d  = out_word_q;
        done_d      = 1'b0;
        flags_d     = flags_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    zacc_d  = 1'b1;
                    carry_d = op[0];
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    carry_d     = op_q[1] ? carry_q : slice_cout;
                    zacc_d      = zacc_q & (slice_r == '0);
                    cnt_d       = cnt_q + 1'b1;
                    out_valid_d = 1'b1;
                    out_word_d  = slice_r;
                    if (cnt_q == LAST) begin
                        state_d         = IDLE;
                        done_d          = 1'b1;
                        flags_d[FLAG_N] = slice_r[WIDTH-1];
                        flags_d[FLAG_Z] = zacc_d;
                        flags_d[FLAG_C] = ~op_q[1] & slice_cout;
                        flags_d[FLAG_V] = slice_ovf;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            done_q      <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            done_q      <= done_d;
            flags_q     <= flags_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign in_ready  = (state_q == RUN);
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign done      = done_q;
    assign flags     = flags_q;

endmodule
